// File: rtl/sub4_sweep.sv
// Exhaustive operand sweep for an external 4-bit subtractor stage.
// Each (a,b) pair is held, sampled, scored, and handed off as a record.
module sub4_sweep #(
  parameter int SETTLE = 2,
  parameter int REPEAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  input  logic [3:0] diff_in,
  output logic       busy,
  output logic       done,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_a,
  output logic [3:0] res_b,
  output logic [3:0] res_diff,
  output logic       res_illegal,
  output logic       res_mismatch,
  output logic [9:0] legal_cnt,
  output logic [9:0] illegal_cnt,
  output logic [9:0] mismatch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [3:0] SLOAD = 4'(SETTLE - 1);
  localparam logic [1:0] PLAST = 2'(REPEAT - 1);

  state_t     state, state_n;
  logic [3:0] scnt;
  logic [1:0] pass;
  logic [3:0] exp_d;
  logic       go, cap, hs, wrap, last;

  assign go   = (state == S_IDLE || state == S_DONE) && start;
  assign cap  = (state == S_SETTLE) && (scnt == 4'd0);
  assign hs   = (state == S_PRESENT) && res_ready;
  assign wrap = (a_out == 4'hf) && (b_out == 4'hf);
  assign last = wrap && (pass == PLAST);

  assign busy      = (state == S_SETTLE) || (state == S_PRESENT);
  assign done      = (state == S_DONE);
  assign res_valid = (state == S_PRESENT);

  assign exp_d        = res_a - res_b;
  assign res_illegal  = res_a < res_b;
  assign res_mismatch = res_diff != exp_d;

  function automatic logic [9:0] sat(input logic [9:0] c);
    return (c == 10'd1023) ? c : c + 10'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = S_SETTLE;
      S_SETTLE:  if (cap) state_n = S_PRESENT;
      S_PRESENT: if (hs) state_n = last ? S_DONE : S_SETTLE;
      S_DONE:    if (start) state_n = S_SETTLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out        <= '0;
      b_out        <= '0;
      scnt         <= '0;
      pass         <= '0;
      res_a        <= '0;
      res_b        <= '0;
      res_diff     <= '0;
      legal_cnt    <= '0;
      illegal_cnt  <= '0;
      mismatch_cnt <= '0;
    end else begin
      if (go) begin
        a_out        <= '0;
        b_out        <= '0;
        pass         <= '0;
        scnt         <= SLOAD;
        legal_cnt    <= '0;
        illegal_cnt  <= '0;
        mismatch_cnt <= '0;
      end
      if (state == S_SETTLE && scnt != 4'd0)
        scnt <= scnt - 4'd1;
      if (cap) begin
        res_a    <= a_out;
        res_b    <= b_out;
        res_diff <= diff_in;
      end
      if (hs) begin
        if (res_illegal) illegal_cnt <= sat(illegal_cnt);
        else             legal_cnt   <= sat(legal_cnt);
        if (res_mismatch) mismatch_cnt <= sat(mismatch_cnt);
        // b is the inner loop; a full wrap closes one pass
        b_out <= b_out + 4'd1;
        if (b_out == 4'hf) a_out <= a_out + 4'd1;
        if (wrap) pass <= pass + 2'd1;
        scnt <= SLOAD;
      end
    end
  end

endmodule

// File: tb/tb_sub4_sweep.sv
// Scoreboarded random bench for sub4_sweep.
// A behavioural sub4 model closes the loop on a_out/b_out.
module tb_sub4_sweep;

  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic [3:0] a_out, b_out, diff_in;
  logic       busy, done, res_valid;
  logic       res_ready = 0;
  logic [3:0] res_a, res_b, res_diff;
  logic       res_illegal, res_mismatch;
  logic [9:0] legal_cnt, illegal_cnt, mismatch_cnt;
  logic       fault = 0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int a;
    int b;
    int d;
    int il;
    int mm;
  } rec_t;
  rec_t q[$];

  sub4_sweep #(.SETTLE(2), .REPEAT(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a_out), .b_out(b_out), .diff_in(diff_in),
    .busy(busy), .done(done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_a(res_a), .res_b(res_b), .res_diff(res_diff),
    .res_illegal(res_illegal), .res_mismatch(res_mismatch),
    .legal_cnt(legal_cnt), .illegal_cnt(illegal_cnt),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  // sub4 stage model; the fault variant has diff bit 0 stuck low
  always_comb begin
    diff_in = a_out - b_out;
    if (fault) diff_in[0] = 1'b0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_run(input bit f);
    rec_t r;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          int t;
          t = (a - b + 16) % 16;
          r.a = a;
          r.b = b;
          r.d = f ? (t & 14) : t;
          r.il = (a < b) ? 1 : 0;
          r.mm = (r.d != t) ? 1 : 0;
          q.push_back(r);
        end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: got record a=%0d b=%0d expected none",
                 res_a, res_b);
      end else begin
        rec_t r;
        r = q.pop_front();
        chk("res_a", res_a, r.a);
        chk("res_b", res_b, r.b);
        chk("res_diff", res_diff, r.d);
        chk("res_illegal", res_illegal, r.il);
        chk("res_mismatch", res_mismatch, r.mm);
      end
    end
  end

  task automatic chk_reset(input string nm);
    chk({nm, "_a_out"}, a_out, 0);
    chk({nm, "_b_out"}, b_out, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_valid"}, res_valid, 0);
    chk({nm, "_res"}, {res_a, res_b, res_diff}, 0);
    chk({nm, "_cnt"}, {legal_cnt, illegal_cnt, mismatch_cnt}, 0);
  endtask

  task automatic kick();
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    chk("kick_busy", busy, 1);
    chk("kick_ops", {a_out, b_out}, 0);
    chk("kick_cnt", {legal_cnt, illegal_cnt, mismatch_cnt}, 0);
  endtask

  task automatic run_to_done(input bit rnd, input int spulse,
                             output int cyc);
    cyc = 0;
    while (!done && cyc < 30000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rnd) res_ready = 1'($urandom_range(0, 1));
      start = (cyc == spulse);
      if (cyc == spulse) chk("pulse_busy", busy, 1);
    end
    start = 0;
    chk("reached_done", done, 1);
  endtask

  initial begin
    int cyc;
    int n;
    logic [23:0] snap;
    logic [29:0] csnap;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst = 0;

    // ideal model, ready high, stray start mid-run
    push_run(0);
    res_ready = 1;
    kick();
    run_to_done(0, 100, cyc);
    chk("run_cycles", cyc, 1536);
    chk("legal", legal_cnt, 272);
    chk("illegal", illegal_cnt, 240);
    chk("mismatch", mismatch_cnt, 0);
    chk("sb_drained", q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_hold", {done, res_valid}, 2'b10);
    chk("done_cnt", legal_cnt, 272);

    // faulty model, random backpressure
    fault = 1;
    push_run(1);
    kick();
    run_to_done(1, 0, cyc);
    chk("f_legal", legal_cnt, 272);
    chk("f_illegal", illegal_cnt, 240);
    chk("f_mismatch", mismatch_cnt, 256);
    chk("f_drained", q.size(), 0);

    // stall then reset mid-PRESENT
    fault = 0;
    res_ready = 1;
    push_run(0);
    kick();
    n = 0;
    while (!(legal_cnt + illegal_cnt == 40 && res_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    res_ready = 0;
    chk("at40", int'(legal_cnt) + int'(illegal_cnt), 40);
    chk("at40_valid", res_valid, 1);
    snap = {res_a, res_b, res_diff, a_out, b_out, 4'h0};
    csnap = {legal_cnt, illegal_cnt, mismatch_cnt};
    repeat (20) @(posedge clk);
    #1;
    chk("stall_res", {res_a, res_b, res_diff, a_out, b_out, 4'h0}, snap);
    chk("stall_cnt", {legal_cnt, illegal_cnt, mismatch_cnt}, csnap);
    chk("stall_valid", res_valid, 1);
    res_ready = 1;
    @(posedge clk);
    #1;
    res_ready = 0;
    chk("release_inc", int'(legal_cnt) + int'(illegal_cnt), 41);
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("pre_rst_valid", res_valid, 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk_reset("mid_rst");
    rst = 0;
    q.delete();

    push_run(0);
    res_ready = 1;
    kick();
    run_to_done(0, 0, cyc);
    chk("rerun_cycles", cyc, 1536);
    chk("rerun_legal", legal_cnt, 272);
    chk("rerun_illegal", illegal_cnt, 240);
    chk("rerun_mismatch", mismatch_cnt, 0);
    chk("rerun_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
